cache_mem_arbiter: RTL and testbench

- Shares the single sram-like memory port toward the AXI bridge between the instruction cache and the data cache (write-back D-cache issues both refills and write-backs).
- Sits between the i_cache/d_cache miss ports and the sram-like-to-AXI bridge.
- Allows one outstanding transaction at a time, with data-side priority and a starvation guard for the instruction side.

---
 rtl/cache_arb_pkg.sv | 17 +
 rtl/cache_arb_grant_sel.sv | 38 +++
 rtl/cache_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared constants for the cache memory-port arbiter: FSM state codes, owner ids, sram-like sizes.
package cache_arb_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR_I = 3'd1;
  localparam logic [2:0] ADDR_D = 3'd2;
  localparam logic [2:0] DATA_I = 3'd3;
  localparam logic [2:0] DATA_D = 3'd4;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cache_arb_grant_sel.sv
// Pure grant decision between I- and D-cache requests.
// With CACHE_ARB_RR_EN defined the tie is broken round-robin, otherwise D wins until the starvation limit.
module cache_arb_grant_sel
  import cache_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       i_req,
  input  logic       d_req,
`ifdef CACHE_ARB_RR_EN
  input  logic       last_grant,
`else
  input  logic [3:0] starve_cnt,
`endif
  output logic       grant_valid,
  output logic       grant_owner
);

`ifndef CACHE_ARB_RR_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
`endif

  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_I;
    if (d_req && !i_req) begin
      grant_owner = OWN_D;
    end else if (d_req && i_req) begin
`ifdef CACHE_ARB_RR_EN
      grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
`else
      // I is forced through once D has won STARVE_LIMIT times while I waited
      grant_owner = (starve_cnt == STARVE_MAX) ? OWN_I : OWN_D;
`endif
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one sram-like bridge port between the I-cache and the write-back D-cache, one transaction at a time.
// Optional macro CACHE_ARB_RR_EN selects round-robin arbitration instead of D priority with a starvation guard.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_wr,
  input  logic [1:0]            i_size,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_addr_ok,
  output logic                  i_data_ok,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [1:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_addr_ok,
  output logic                  d_data_ok,
  output logic                  m_req,
  output logic                  m_wr,
  output logic [1:0]            m_size,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_addr_ok,
  input  logic                  m_data_ok
);

  logic [2:0] state;
  logic       grant_valid;
  logic       grant_owner;
  logic       grant_fire;
  logic       owner_d;
  logic       in_addr;
  logic       in_data;

  assign owner_d    = (state == ADDR_D) || (state == DATA_D);
  assign in_addr    = (state == ADDR_I) || (state == ADDR_D);
  assign in_data    = (state == DATA_I) || (state == DATA_D);
  assign grant_fire = (state == IDLE) && grant_valid;

`ifdef CACHE_ARB_RR_EN
  logic last_grant;

  cache_arb_grant_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_I;
    end else if (grant_fire) begin
      last_grant <= grant_owner;
    end
  end
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  cache_arb_grant_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  // Counts D grants that made a waiting I request wait longer; any I grant clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (grant_fire) begin
      if (grant_owner == OWN_I) begin
        starve_cnt <= 4'd0;
      end else if (i_req && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state <= (grant_owner == OWN_D) ? ADDR_D : ADDR_I;
          end
        end
        ADDR_I: begin
          if (!i_req) begin
            state <= IDLE;
          end else if (m_addr_ok) begin
            state <= DATA_I;
          end
        end
        ADDR_D: begin
          if (!d_req) begin
            state <= IDLE;
          end else if (m_addr_ok) begin
            state <= DATA_D;
          end
        end
        DATA_I: begin
          if (m_data_ok) begin
            state <= IDLE;
          end
        end
        DATA_D: begin
          if (m_data_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bridge handshakes reach only the current owner and only in the matching phase
  always_comb begin
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_size    = 2'd0;
    m_addr    = '0;
    m_wdata   = '0;
    i_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    d_addr_ok = 1'b0;
    d_data_ok = 1'b0;
    i_rdata   = m_rdata;
    d_rdata   = m_rdata;
    if (in_addr || in_data) begin
      m_wr    = owner_d ? d_wr    : i_wr;
      m_size  = owner_d ? d_size  : i_size;
      m_addr  = owner_d ? d_addr  : i_addr;
      m_wdata = owner_d ? d_wdata : i_wdata;
    end
    if (in_addr) begin
      m_req     = owner_d ? d_req : i_req;
      i_addr_ok = !owner_d && i_req && m_addr_ok;
      d_addr_ok = owner_d && d_req && m_addr_ok;
    end
    if (in_data) begin
      i_data_ok = !owner_d && m_data_ok;
      d_data_ok = owner_d && m_data_ok;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: transaction-level reference model, scripted bridge, directed scenarios.
// Honours CACHE_ARB_RR_EN so the same bench checks either arbitration build.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, i_wr = 1'b0;
  logic [1:0]    i_size = 2'd0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic [DW-1:0] i_rdata;
  logic          i_addr_ok, i_data_ok;
  logic          d_req = 1'b0, d_wr = 1'b0;
  logic [1:0]    d_size = 2'd0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_addr_ok, d_data_ok;
  logic          m_req, m_wr;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_addr_ok = 1'b0, m_data_ok = 1'b0;

  cache_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          cyc;
  } acc_t;

  op_t  iQ[$];
  op_t  dQ[$];
  acc_t accLog[$];

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  bit checking = 0;
  bit iAcc = 0, dAcc = 0;
  int iAddrOkCnt = 0, dAddrOkCnt = 0, iDataOkCnt = 0, dDataOkCnt = 0;
  int dAddrOkCyc = -1, dDataOkCyc = -1;
  logic [31:0] dDataSeen = '0;

  int brAddrDelay = 0, brDataDelay = 0, brCnt = 0, brSeq = 0;
  bit brPhase = 0, brStray = 0;
  logic [31:0] brRdataQ[$];

  // Reference model: which side owns the port and which phase it is in
  int mPhase = 0;
  bit mOwnD = 0;
  int mStreak = 0;
  bit mLastD = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pickD(input bit iReq, input bit dReq, input int streak, input bit lastD);
    if (!iReq) return 1'b1;
    if (!dReq) return 1'b0;
`ifdef CACHE_ARB_RR_EN
    return !lastD;
`else
    return streak < LIMIT;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mPhase = 0; mOwnD = 0; mStreak = 0; mLastD = 0;
    end else begin
      case (mPhase)
        0: if (i_req || d_req) begin
          mOwnD = pickD(i_req, d_req, mStreak, mLastD);
          if (!mOwnD) mStreak = 0;
          else if (i_req && mStreak < LIMIT) mStreak = mStreak + 1;
          mLastD = mOwnD;
          mPhase = 1;
        end
        1: if (!(mOwnD ? d_req : i_req)) mPhase = 0;
           else if (m_addr_ok) mPhase = 2;
        default: if (m_data_ok) mPhase = 0;
      endcase
    end
  end

  // Scripted bridge: addr_ok and data_ok after programmable delays, optional stray data_ok
  always @(posedge clk) begin
    #2;
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    if (rst) begin
      brPhase = 0; brCnt = 0; brStray = 0; m_rdata = '0;
    end else begin
      if (brPhase) begin
        if (brCnt >= brDataDelay) begin
          m_data_ok = 1'b1;
          if (brRdataQ.size() > 0) m_rdata = brRdataQ.pop_front();
          else m_rdata = 32'hC0DE_0000 + 32'(brSeq);
          brSeq++; brPhase = 0; brCnt = 0;
        end else brCnt++;
      end else if (m_req) begin
        if (brCnt >= brAddrDelay) begin
          m_addr_ok = 1'b1; brPhase = 1; brCnt = 0;
        end else brCnt++;
      end else brCnt = 0;
      if (brStray) begin
        m_data_ok = 1'b1; brStray = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (iAcc) begin if (iQ.size() > 0) void'(iQ.pop_front()); iAcc = 0; end
    if (dAcc) begin if (dQ.size() > 0) void'(dQ.pop_front()); dAcc = 0; end
    if (iQ.size() > 0) begin
      i_req = 1; i_wr = iQ[0].wr; i_size = iQ[0].size; i_addr = iQ[0].addr; i_wdata = iQ[0].wdata;
    end else begin
      i_req = 0; i_wr = 0; i_size = 0; i_addr = '0; i_wdata = '0;
    end
    if (dQ.size() > 0) begin
      d_req = 1; d_wr = dQ[0].wr; d_size = dQ[0].size; d_addr = dQ[0].addr; d_wdata = dQ[0].wdata;
    end else begin
      d_req = 0; d_wr = 0; d_size = 0; d_addr = '0; d_wdata = '0;
    end
  end

  always @(negedge clk) begin : cmp
    logic ownReq;
    logic [31:0] eAddr, eWdata;
    if (checking) begin
      ownReq = mOwnD ? d_req : i_req;
      eAddr  = mOwnD ? d_addr : i_addr;
      eWdata = mOwnD ? d_wdata : i_wdata;
      checkOutput("m_req", m_req, (mPhase == 1) && ownReq);
      checkOutput("i_addr_ok", i_addr_ok, (mPhase == 1) && !mOwnD && ownReq && m_addr_ok);
      checkOutput("d_addr_ok", d_addr_ok, (mPhase == 1) && mOwnD && ownReq && m_addr_ok);
      checkOutput("i_data_ok", i_data_ok, (mPhase == 2) && !mOwnD && m_data_ok);
      checkOutput("d_data_ok", d_data_ok, (mPhase == 2) && mOwnD && m_data_ok);
      if (mPhase != 0) begin
        checkOutput("m_addr", m_addr, eAddr);
        checkOutput("m_wdata", m_wdata, eWdata);
      end
      if (mPhase == 1) begin
        checkOutput("m_wr", m_wr, mOwnD ? d_wr : i_wr);
        checkOutput("m_size", m_size, mOwnD ? d_size : i_size);
      end
      if (i_data_ok) checkOutput("i_rdata", i_rdata, m_rdata);
      if (d_data_ok) checkOutput("d_rdata", d_rdata, m_rdata);
    end
    if (i_addr_ok) begin iAcc = 1; iAddrOkCnt++; end
    if (d_addr_ok) begin dAcc = 1; dAddrOkCnt++; if (dAddrOkCyc < 0) dAddrOkCyc = cyc; end
    if (i_data_ok) iDataOkCnt++;
    if (d_data_ok) begin
      dDataOkCnt++;
      if (dDataOkCyc < 0) begin dDataOkCyc = cyc; dDataSeen = d_rdata; end
    end
    if (m_req && m_addr_ok) accLog.push_back('{m_addr, m_wr, m_size, m_wdata, cyc});
  end

  task automatic clearMonitors();
    accLog.delete();
    iAddrOkCnt = 0; dAddrOkCnt = 0; iDataOkCnt = 0; dDataOkCnt = 0;
    dAddrOkCyc = -1; dDataOkCyc = -1;
  endtask

  task automatic applyReset();
    @(negedge clk); #2;
    rst = 1; iQ.delete(); dQ.delete(); iAcc = 0; dAcc = 0; brStray = 0; brRdataQ.delete();
    @(negedge clk); #2;
    rst = 0;
    clearMonitors();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_m_req"}, m_req, 0);
    checkOutput({tag, "_m_wr"}, m_wr, 0);
    checkOutput({tag, "_m_size"}, m_size, 0);
    checkOutput({tag, "_m_addr"}, m_addr, 0);
    checkOutput({tag, "_m_wdata"}, m_wdata, 0);
    checkOutput({tag, "_handshakes"}, {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
  endtask

  task automatic pushOp(input bit toD, input logic [31:0] addr, input logic wr,
                        input logic [1:0] size, input logic [31:0] wdata);
    op_t o;
    o.addr = addr; o.wr = wr; o.size = size; o.wdata = wdata;
    if (toD) dQ.push_back(o); else iQ.push_back(o);
  endtask

  task automatic applyStimulus(input string name, input int budget);
    int n = 0;
    while ((iQ.size() > 0 || dQ.size() > 0 || mPhase != 0 || brPhase) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (2) @(negedge clk);
    #1;
    nCompared++;
    if (n >= budget) begin
      nMismatched++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles, limit %0d", name, n, budget);
    end
  endtask

`ifdef CACHE_ARB_RR_EN
  localparam int IPOS0 = 1;
  localparam int IPOS1 = 3;
`else
  localparam int IPOS0 = 4;
  localparam int IPOS1 = 9;
`endif

  initial begin
    int startCyc;
    bit expI;
    int n;

    $display("[TB] cache_mem_arbiter bench start");
    applyReset();
    checking = 1;
    checkIdleOutputs("reset");

    // D-only read with one-cycle bridge delays
    brAddrDelay = 1; brDataDelay = 1;
    brRdataQ.push_back(32'hDEAD_BEEF);
    @(negedge clk); #1;
    pushOp(1, 32'h0000_1000, 0, SZ_WORD, 32'h0);
    startCyc = cyc + 1;
    applyStimulus("s1", 50);
    checkOutput("s1_addr_ok_cycle", dAddrOkCyc - startCyc, 2);
    checkOutput("s1_data_ok_cycle", dDataOkCyc - startCyc, 4);
    checkOutput("s1_rdata", dDataSeen, 32'hDEAD_BEEF);
    checkOutput("s1_i_handshakes", iAddrOkCnt + iDataOkCnt, 0);

    // Simultaneous requests: D first, I after an IDLE cycle
    applyReset();
    brAddrDelay = 0; brDataDelay = 0;
    @(negedge clk); #1;
    pushOp(0, 32'h0040_0000, 0, SZ_WORD, 32'h0);
    pushOp(1, 32'h1000_0000, 0, SZ_WORD, 32'h0);
    applyStimulus("s2", 50);
    checkOutput("s2_count", accLog.size(), 2);
    if (accLog.size() >= 2) begin
      checkOutput("s2_first_addr", accLog[0].addr, 32'h1000_0000);
      checkOutput("s2_second_addr", accLog[1].addr, 32'h0040_0000);
      checkOutput("s2_gap", accLog[1].cyc - accLog[0].cyc, 3);
    end

    // Continuous D pressure with I waiting: starvation guard / alternation
    applyReset();
    @(negedge clk); #1;
    for (int k = 0; k < 10; k++) pushOp(1, 32'h2000_0000 + 32'(k * 16), 0, SZ_WORD, 32'h0);
    pushOp(0, 32'h0040_0100, 0, SZ_WORD, 32'h0);
    pushOp(0, 32'h0040_0200, 0, SZ_WORD, 32'h0);
    applyStimulus("s3", 200);
    checkOutput("s3_grants", accLog.size(), 12);
    for (int k = 0; k < accLog.size() && k < 12; k++) begin
      expI = (k == IPOS0) || (k == IPOS1);
      checkOutput($sformatf("s3_owner_is_i_%0d", k), accLog[k].addr[31:28] == 4'h0, expI);
    end

    // Write-back then refill, followed by a stray data_ok while idle
    applyReset();
    @(negedge clk); #1;
    pushOp(1, 32'h0000_2000, 1, SZ_WORD, 32'h1234_5678);
    pushOp(1, 32'h0000_2000, 0, SZ_WORD, 32'h0);
    applyStimulus("s4", 50);
    brStray = 1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("s4_count", accLog.size(), 2);
    if (accLog.size() >= 2) begin
      checkOutput("s4_wb_wr", accLog[0].wr, 1);
      checkOutput("s4_wb_wdata", accLog[0].wdata, 32'h1234_5678);
      checkOutput("s4_wb_size", accLog[0].size, SZ_WORD);
      checkOutput("s4_refill_wr", accLog[1].wr, 0);
    end
    checkOutput("s4_d_data_ok_pulses", dDataOkCnt, 2);
    checkOutput("s4_i_data_ok_pulses", iDataOkCnt, 0);

    // Reset while D waits for data; the aborted request must never complete
    applyReset();
    brAddrDelay = 0; brDataDelay = 6;
    @(negedge clk); #1;
    pushOp(1, 32'h0000_3000, 0, SZ_WORD, 32'h0);
    n = 0;
    while (dAddrOkCnt == 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("s5_addr_accepted", dAddrOkCnt, 1);
    applyReset();
    checkIdleOutputs("s5_after_rst");
    brDataDelay = 0;
    @(negedge clk); #1;
    brStray = 1;
    repeat (8) @(negedge clk);
    #1;
    checkOutput("s5_d_data_ok_pulses", dDataOkCnt, 0);
    checkOutput("s5_i_data_ok_pulses", iDataOkCnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
